// File: rtl/div_pkg.sv
// Shared types and default sizes for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;
  localparam int CNT_W  = $clog2(DEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not borrow.
module div_restore_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   prem,
  input  logic          nbit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   prem_next,
  output logic          qbit
);

  // Kept one bit wider than the partial remainder so the compare never wraps.
  logic [VW+1:0] sh;
  logic [VW:0]   diff;
  logic          nonneg;

  assign sh     = {prem, nbit};
  assign nonneg = (sh >= {2'b00, divisor});
  // When the trial succeeds the result is below the divisor, so VW+1 bits suffice.
  assign diff   = sh[VW:0] - {1'b0, divisor};

  // Restore (keep shifted value) on borrow, otherwise take the difference.
  always_comb begin
    prem_next = sh[VW:0];
    qbit      = 1'b0;
    if (nonneg) begin
      prem_next = diff;
      qbit      = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div8by4.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per cycle, valid/ready on both sides, no overlap of operations.
module seq_div8by4
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dreg;
  logic [VW:0]   rem;
  logic [VW-1:0] dvs;
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r;
  logic          dbz_r;

  logic [VW:0]   rem_nxt;
  logic          qbit;

  div_restore_step #(.VW(VW)) u_step (
    .prem      (rem),
    .nbit      (dreg[DW-1]),
    .divisor   (dvs),
    .prem_next (rem_nxt),
    .qbit      (qbit)
  );

  assign quotient    = q_r;
  assign remainder   = r_r;
  assign div_by_zero = dbz_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and handshake outputs; in_valid is only looked at in IDLE.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle step, and result registers that
  // are only written when a result completes, so they hold through DONE
  // and after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      dreg  <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dreg <= dividend;
            dvs  <= divisor;
            rem  <= '0;
            cnt  <= '0;
            if (divisor == '0) begin
              q_r   <= '1;
              r_r   <= '0;
              dbz_r <= 1'b1;
            end
          end
        end
        CALC: begin
          dreg <= {dreg[DW-2:0], qbit};
          rem  <= rem_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            q_r   <= {dreg[DW-2:0], qbit};
            r_r   <= rem_nxt[VW-1:0];
            dbz_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_div8by4.md
Name: seq_div8by4

Overview:
- Sequential restoring divider. It is the inverse of the team's 4x4 multiplier: it takes an 8-bit product-width dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- Used to check multiplier outputs (P / B == A, remainder 0) and as a general divide datapath element.
- Produces one quotient bit per cycle.
- Valid/ready handshakes on both input and output.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DW  numerator, unsigned.
- divisor  in  VW  denominator, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DW  unsigned quotient.
- remainder  out  VW  unsigned remainder.
- div_by_zero  out  1  set with result when divisor == 0.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
  - Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (cycle t), latch dividend into the shift register and divisor into the divisor register, and clear the partial remainder (VW+1 bits).
  - If divisor != 0, go to CALC with counter=0.
  - If divisor == 0, go directly to DONE with quotient = all ones, remainder = 0, div_by_zero = 1. out_valid rises at t+1.
- CALC, one restoring step per cycle (MSB first):
  - Shift {partial remainder, dividend register} left by 1.
  - Trial = partial remainder − {0, divisor}, evaluated VW+1 bits wide.
  - If trial is non-negative (no borrow), take partial remainder = trial and quotient bit = 1.
  - Otherwise keep the partial remainder and set quotient bit = 0.
  - The quotient bit shifts into the LSB of the dividend register.
  - Counter increments each step. After step DW−1, go to DONE.
  - out_valid first high at cycle t+DW+1; latency from accept to out_valid is DW+1 = 9 cycles.
  - in_ready=0 throughout CALC and DONE. There is no overlap of operations.
- DONE:
  - out_valid=1.
  - quotient, remainder and div_by_zero are held stable until out_valid && out_ready.
  - Result handshake at cycle u: go to IDLE. At u+1, out_valid=0 and in_ready=1.
  - Outputs keep their last values after handshake. Only out_valid qualifies them.
- Backpressure: out_ready low holds DONE indefinitely with outputs frozen.
- Operand changes: changes on the dividend or divisor inputs while not in IDLE are ignored.
- Width rules:
  - Partial remainder is VW+1 bits so the subtract cannot overflow.
  - The final remainder is the low VW bits and is always < divisor.
  - Arithmetic is unsigned throughout.
- Invariant: for divisor != 0, quotient*divisor + remainder == dividend.
- Reset mid-operation: an rst_n low in any state returns all registers to their reset values on that clock edge. The in-flight operation is discarded and no out_valid is produced.
- Simultaneous events:
  - in_valid is ignored in DONE, even in the same cycle as the output handshake.
  - A new operation can be accepted no earlier than u+1.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - default DW/VW constants;
  - counter width localparam, $clog2(DW).
- One combinational sub-module, div_restore_step:
  - Inputs: partial remainder (VW+1), next dividend bit, divisor (VW).
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once in the CALC datapath; also unit-testable on its own.

Test Plan:
- Basic division: dividend=200, divisor=7 -> after 9 cycles, out_valid=1, quotient=28, remainder=4, div_by_zero=0; in_ready low for all 9 cycles.
- Multiplier round-trip: dividend=143 (13*11), divisor=11 -> quotient=13, remainder=0. Also sweep all A,B in 1..15 with P=A*B: quotient==A, remainder==0.
- Boundaries:
  - 255/1 -> 255 r0.
  - 15/15 -> 1 r0.
  - 7/9 -> 0 r7.
  - 0/5 -> 0 r0.
  - 255/15 -> 17 r0.
- Divide by zero: dividend=100, divisor=0 -> out_valid at t+1, quotient=0xFF, remainder=0, div_by_zero=1; next op 100/3 -> 33 r1 with div_by_zero=0.
- Backpressure: out_ready held low for 20 cycles after result of 200/7 -> outputs stable at 28/4, in_ready=0, in_valid pulses ignored; release -> in_ready=1 one cycle after handshake.
- Mid-operation reset: assert rst_n=0 at step 4 of 200/7 -> next cycle state IDLE, out_valid=0, in_ready=1, outputs 0; a following 50/6 completes as 8 r2.
